congestion_estimator: RTL and testbench

Producer side of the traffic controller's congestion interface: turns per-frame vehicle counts from the vision/ML front end into the 2-bit `congestion_level` and `fail_safe_en` that the traffic controller consumes. Smooths counts over a 4-frame moving average, classifies them with hysteresis, and runs a frame watchdog that requests fail-safe mode when frame results stop arriving. Sits between the inference core and the traffic controller, in the same clock domain.

---
 rtl/traffic_pkg.sv | 37 +++
 rtl/frame_watchdog.sv | 65 ++++++
 rtl/congestion_estimator.sv | 154 +++++++++++++++
 tb/tb_congestion_estimator.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Types and default thresholds shared by the congestion estimator and the
// traffic controller so both sides agree on the level encoding.
package traffic_pkg;

  typedef logic [1:0] level_t;

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    FAILSAFE = 2'd1,
    RECOVER  = 2'd2
  } est_state_t;

  localparam int unsigned DEF_T1   = 10;
  localparam int unsigned DEF_T2   = 25;
  localparam int unsigned DEF_T3   = 45;
  localparam int unsigned DEF_HYST = 3;

  function automatic level_t classify_level(
    input logic [8:0] x,
    input logic [8:0] t1,
    input logic [8:0] t2,
    input logic [8:0] t3
  );
    level_t lvl;
    if (x >= t3) begin
      lvl = 2'd3;
    end else if (x >= t2) begin
      lvl = 2'd2;
    end else if (x >= t1) begin
      lvl = 2'd1;
    end else begin
      lvl = 2'd0;
    end
    return lvl;
  endfunction

endpackage

// File: rtl/frame_watchdog.sv
// Frame watchdog: counts cycles between frame results, flags an expiry when a
// frame period passes without one, and tracks consecutive misses.
module frame_watchdog #(
  parameter int unsigned FRAME_CYCLES = 5000,
  parameter int unsigned MISS_LIMIT   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       count_valid_i,
  input  logic       frame_err_i,
  output logic       expire_o,
  output logic       limit_hit_o,
  output logic [3:0] miss_count_o
);

  localparam int unsigned CW = $clog2(FRAME_CYCLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_CYCLES - 1);
  localparam logic [4:0] LIMIT = (MISS_LIMIT > 15) ? 5'd16 : 5'(MISS_LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    miss_q, miss_d;
  logic          expire_s;
  logic          good_s;
  logic          bad_s;

  // Next-state for the cycle counter and the consecutive-miss counter.
  always_comb begin
    good_s   = count_valid_i && !frame_err_i;
    bad_s    = count_valid_i && frame_err_i;
    expire_s = (cnt_q == LAST_CNT) && !count_valid_i;

    // The cycle after a frame is already one elapsed cycle of the next period.
    if (count_valid_i) begin
      cnt_d = CW'(1);
    end else if (cnt_q == LAST_CNT) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    if (good_s) begin
      miss_d = 4'd0;
    end else if ((bad_s || expire_s) && (miss_q != 4'd15)) begin
      miss_d = miss_q + 4'd1;
    end else begin
      miss_d = miss_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      miss_q <= 4'd0;
    end else begin
      cnt_q  <= cnt_d;
      miss_q <= miss_d;
    end
  end

  assign expire_o     = expire_s;
  assign miss_count_o = miss_q;
  assign limit_hit_o  = ({1'b0, miss_q} >= LIMIT);

endmodule

// File: rtl/congestion_estimator.sv
// Turns per-frame vehicle counts into a hysteretic congestion level and a
// fail-safe request driven by a frame watchdog.
module congestion_estimator
  import traffic_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES   = 5000,
  parameter int unsigned T1             = DEF_T1,
  parameter int unsigned T2             = DEF_T2,
  parameter int unsigned T3             = DEF_T3,
  parameter int unsigned HYST           = DEF_HYST,
  parameter int unsigned MISS_LIMIT     = 3,
  parameter int unsigned RECOVER_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] vehicle_count,
  input  logic       count_valid,
  input  logic       frame_err,
  output level_t     congestion_level,
  output logic       level_valid,
  output logic       fail_safe_en,
  output logic [3:0] miss_count
);

  localparam logic [8:0] TH1      = 9'(T1);
  localparam logic [8:0] TH2      = 9'(T2);
  localparam logic [8:0] TH3      = 9'(T3);
  localparam logic [8:0] HYST9    = 9'(HYST);
  localparam logic [7:0] REC_LAST = 8'(RECOVER_FRAMES - 1);

  logic [3:0][7:0] hist_q;
  logic [9:0]      sum_q, sum_d;
  logic            s1_vld_q;
  level_t          level_q, level_d;
  logic            lvl_vld_q;
  est_state_t      st_q;
  logic [7:0]      rec_q;
  logic            fs_q;

  logic            good_s;
  logic            bad_s;
  logic [8:0]      avg_up_s;
  logic [8:0]      avg_dn_s;
  level_t          up_s;
  level_t          dn_s;
  logic            expire_s;
  logic            limit_hit_s;

  frame_watchdog #(
    .FRAME_CYCLES (FRAME_CYCLES),
    .MISS_LIMIT   (MISS_LIMIT)
  ) u_watchdog (
    .clk           (clk),
    .rst_n         (rst_n),
    .count_valid_i (count_valid),
    .frame_err_i   (frame_err),
    .expire_o      (expire_s),
    .limit_hit_o   (limit_hit_s),
    .miss_count_o  (miss_count)
  );

  // Running sum and hysteretic level decision.
  always_comb begin
    good_s   = count_valid && !frame_err;
    bad_s    = count_valid && frame_err;
    // sum_q always equals the sum of hist_q, so only the oldest entry leaves.
    sum_d    = sum_q - 10'(hist_q[3]) + 10'(vehicle_count);
    avg_up_s = {1'b0, sum_q[9:2]};
    avg_dn_s = {1'b0, sum_q[9:2]} + HYST9;
    up_s     = classify_level(avg_up_s, TH1, TH2, TH3);
    dn_s     = classify_level(avg_dn_s, TH1, TH2, TH3);
    if (up_s > level_q) begin
      level_d = up_s;
    end else if (dn_s < level_q) begin
      level_d = dn_s;
    end else begin
      level_d = level_q;
    end
  end

  // Two-stage pipeline: history/sum, then level with its valid pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q    <= '0;
      sum_q     <= 10'd0;
      s1_vld_q  <= 1'b0;
      level_q   <= 2'd0;
      lvl_vld_q <= 1'b0;
    end else begin
      if (good_s) begin
        hist_q <= {hist_q[2:0], vehicle_count};
        sum_q  <= sum_d;
      end
      s1_vld_q <= good_s;
      if (s1_vld_q) begin
        level_q <= level_d;
      end
      lvl_vld_q <= s1_vld_q;
    end
  end

  // Fail-safe state machine with registered request output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q  <= NORMAL;
      rec_q <= 8'd0;
      fs_q  <= 1'b0;
    end else begin
      case (st_q)
        NORMAL: begin
          if (limit_hit_s) begin
            st_q <= FAILSAFE;
            fs_q <= 1'b1;
          end
        end
        FAILSAFE: begin
          if (good_s) begin
            if (REC_LAST == 8'd0) begin
              st_q <= NORMAL;
              fs_q <= 1'b0;
            end else begin
              st_q  <= RECOVER;
              rec_q <= 8'd1;
            end
          end
        end
        RECOVER: begin
          if (bad_s || expire_s) begin
            st_q  <= FAILSAFE;
            rec_q <= 8'd0;
          end else if (good_s) begin
            if (rec_q >= REC_LAST) begin
              st_q  <= NORMAL;
              rec_q <= 8'd0;
              fs_q  <= 1'b0;
            end else begin
              rec_q <= rec_q + 8'd1;
            end
          end
        end
        default: begin
          st_q  <= NORMAL;
          rec_q <= 8'd0;
          fs_q  <= 1'b0;
        end
      endcase
    end
  end

  assign congestion_level = level_q;
  assign level_valid      = lvl_vld_q;
  assign fail_safe_en     = fs_q;

endmodule

// File: tb/tb_congestion_estimator.sv
// Directed, table-driven bench for congestion_estimator with hand-computed
// expectations plus sequences for watchdog, recovery and reset corners.
module tb_congestion_estimator;

  localparam int FC = 5000;

  logic       clk;
  logic       rst_n;
  logic [7:0] vehicle_count;
  logic       count_valid;
  logic       frame_err;
  logic [1:0] congestion_level;
  logic       level_valid;
  logic       fail_safe_en;
  logic [3:0] miss_count;

  int errors;
  int checks;

  typedef struct {
    logic [7:0] cnt;
    logic       err;
    logic [1:0] lvl;
    logic       lv;
    logic [3:0] miss;
  } vec_t;

  vec_t vecs [15];

  congestion_estimator dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .vehicle_count    (vehicle_count),
    .count_valid      (count_valid),
    .frame_err        (frame_err),
    .congestion_level (congestion_level),
    .level_valid      (level_valid),
    .fail_safe_en     (fail_safe_en),
    .miss_count       (miss_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c, input logic e);
    vehicle_count = c;
    frame_err     = e;
    count_valid   = 1'b1;
    tick();
    count_valid   = 1'b0;
    frame_err     = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst_n         = 1'b0;
    vehicle_count = 8'd0;
    count_valid   = 1'b0;
    frame_err     = 1'b0;

    //            cnt     err   lvl   lv    miss
    vecs[0]  = '{8'd30,  1'b0, 2'd0, 1'b1, 4'd0};
    vecs[1]  = '{8'd30,  1'b0, 2'd1, 1'b1, 4'd0};
    vecs[2]  = '{8'd30,  1'b0, 2'd1, 1'b1, 4'd0};
    vecs[3]  = '{8'd30,  1'b0, 2'd2, 1'b1, 4'd0};
    vecs[4]  = '{8'd0,   1'b1, 2'd2, 1'b0, 4'd1};
    vecs[5]  = '{8'd22,  1'b0, 2'd2, 1'b1, 4'd0};
    vecs[6]  = '{8'd14,  1'b0, 2'd2, 1'b1, 4'd0};
    vecs[7]  = '{8'd10,  1'b0, 2'd1, 1'b1, 4'd0};
    vecs[8]  = '{8'd10,  1'b0, 2'd1, 1'b1, 4'd0};
    vecs[9]  = '{8'd0,   1'b0, 2'd1, 1'b1, 4'd0};
    vecs[10] = '{8'd0,   1'b0, 2'd0, 1'b1, 4'd0};
    vecs[11] = '{8'd255, 1'b0, 2'd3, 1'b1, 4'd0};
    vecs[12] = '{8'd255, 1'b0, 2'd3, 1'b1, 4'd0};
    vecs[13] = '{8'd255, 1'b0, 2'd3, 1'b1, 4'd0};
    vecs[14] = '{8'd255, 1'b0, 2'd3, 1'b1, 4'd0};

    do_reset();
    chk("reset_level", 32'(congestion_level), 32'd0);
    chk("reset_lv",    32'(level_valid),      32'd0);
    chk("reset_fs",    32'(fail_safe_en),     32'd0);
    chk("reset_miss",  32'(miss_count),       32'd0);

    // Ramp, bad-frame discard, hysteresis and saturation-free 255 averaging.
    for (int i = 0; i < 15; i++) begin
      send(vecs[i].cnt, vecs[i].err);
      chk($sformatf("vec%0d_lv_n1", i),   32'(level_valid),  32'd0);
      chk($sformatf("vec%0d_miss", i),    32'(miss_count),   32'(vecs[i].miss));
      chk($sformatf("vec%0d_fs", i),      32'(fail_safe_en), 32'd0);
      tick();
      chk($sformatf("vec%0d_lv_n2", i),   32'(level_valid),      32'(vecs[i].lv));
      chk($sformatf("vec%0d_level", i),   32'(congestion_level), 32'(vecs[i].lvl));
    end

    // Back-to-back good frames: avg 25 then 50.
    do_reset();
    vehicle_count = 8'd100;
    frame_err     = 1'b0;
    count_valid   = 1'b1;
    tick();
    tick();
    count_valid   = 1'b0;
    chk("b2b_lv0",  32'(level_valid),      32'd1);
    chk("b2b_lvl0", 32'(congestion_level), 32'd2);
    tick();
    chk("b2b_lv1",  32'(level_valid),      32'd1);
    chk("b2b_lvl1", 32'(congestion_level), 32'd3);
    tick();
    chk("b2b_lv2",  32'(level_valid),      32'd0);

    // Reset between frame and its level_valid drops the in-flight result.
    send(8'd200, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rstmid_lv",    32'(level_valid),      32'd0);
    chk("rstmid_level", 32'(congestion_level), 32'd0);
    tick();
    chk("rstmid_lv2",   32'(level_valid),      32'd0);
    chk("rstmid_level2", 32'(congestion_level), 32'd0);
    send(8'd40, 1'b0);
    tick();
    chk("rstmid_hist_lv",  32'(level_valid),      32'd1);
    chk("rstmid_hist_lvl", 32'(congestion_level), 32'd1);

    // Miss counter saturates at 15 under repeated bad frames.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      send(8'd5, 1'b1);
    end
    chk("sat_miss", 32'(miss_count), 32'd15);
    tick();
    chk("sat_miss2", 32'(miss_count),   32'd15);
    chk("sat_fs",    32'(fail_safe_en), 32'd1);

    // Bad frames into FAILSAFE, then a bad frame during RECOVER.
    do_reset();
    send(8'd5, 1'b1);
    send(8'd5, 1'b1);
    send(8'd5, 1'b1);
    chk("bad3_miss", 32'(miss_count),   32'd3);
    chk("bad3_fs0",  32'(fail_safe_en), 32'd0);
    tick();
    chk("bad3_fs1",  32'(fail_safe_en), 32'd1);
    send(8'd5, 1'b0);
    chk("rec1_fs",   32'(fail_safe_en), 32'd1);
    chk("rec1_miss", 32'(miss_count),   32'd0);
    send(8'd5, 1'b1);
    chk("recbad_fs",   32'(fail_safe_en), 32'd1);
    chk("recbad_miss", 32'(miss_count),   32'd1);
    send(8'd5, 1'b0);
    chk("rec2_fs", 32'(fail_safe_en), 32'd1);
    send(8'd5, 1'b0);
    chk("rec3_fs", 32'(fail_safe_en), 32'd0);

    // Watchdog misses at N+FC, N+2FC, N+3FC; fail-safe at N+3FC+1.
    do_reset();
    send(8'd0, 1'b0);
    repeat (FC - 2) tick();
    chk("wd_pre1", 32'(miss_count), 32'd0);
    tick();
    chk("wd_m1", 32'(miss_count), 32'd1);
    repeat (FC - 1) tick();
    chk("wd_pre2", 32'(miss_count), 32'd1);
    tick();
    chk("wd_m2", 32'(miss_count), 32'd2);
    repeat (FC - 1) tick();
    tick();
    chk("wd_m3",  32'(miss_count),   32'd3);
    chk("wd_fs0", 32'(fail_safe_en), 32'd0);
    tick();
    chk("wd_fs1", 32'(fail_safe_en), 32'd1);
    send(8'd0, 1'b0);
    chk("wdrec1_fs", 32'(fail_safe_en), 32'd1);
    send(8'd0, 1'b0);
    chk("wdrec2_fs", 32'(fail_safe_en), 32'd0);

    // Frame arriving on the expiry cycle wins; next miss is a full period later.
    do_reset();
    send(8'd0, 1'b0);
    repeat (FC - 2) tick();
    send(8'd0, 1'b0);
    chk("exp_frame_miss", 32'(miss_count), 32'd0);
    repeat (FC - 2) tick();
    chk("exp_next_pre", 32'(miss_count), 32'd0);
    tick();
    chk("exp_next_miss", 32'(miss_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
